mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 41 ++++
 rtl/mem_load_ext.sv | 27 ++
 rtl/mem_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared definitions: LSB opcodes, FSM states,
// IO region tag and access-size helpers.
package mem_ctrl_pkg;

  localparam logic [6:0] OP_LB  = 7'd1;
  localparam logic [6:0] OP_LH  = 7'd2;
  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_LBU = 7'd4;
  localparam logic [6:0] OP_LHU = 7'd5;
  localparam logic [6:0] OP_SB  = 7'd6;
  localparam logic [6:0] OP_SH  = 7'd7;
  localparam logic [6:0] OP_SW  = 7'd8;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  localparam logic [1:0] MC_IO_BASE_HI = 2'b11;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  function automatic logic [2:0] op_size(
    input logic [6:0] op
  );
    unique case (1'b1)
      (op == OP_LB),
      (op == OP_LBU),
      (op == OP_SB):  op_size = SZ_B;
      (op == OP_LH),
      (op == OP_LHU),
      (op == OP_SH):  op_size = SZ_H;
      default:        op_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result extension: sign/zero extends an assembled
// little-endian word according to the load opcode.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [31:0] word,
  output logic [31:0] res
);

  always_comb begin
    res = word;
    unique case (1'b1)
      (op == OP_LB):
        res = {{24{word[7]}}, word[7:0]};
      (op == OP_LH):
        res = {{16{word[15]}}, word[15:0]};
      (op == OP_LBU):
        res = {24'b0, word[7:0]};
      (op == OP_LHU):
        res = {16'b0, word[15:0]};
      default:
        res = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller for LSB and fetch.
// Optional IO store backpressure: MC_IO_BACKPRESSURE_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_BASE_HI = MC_IO_BASE_HI
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              wrong_commit,
  input  logic              lsb_enable,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_data,
  input  logic              lsb_is_load,
  input  logic [6:0]        lsb_op,
  output logic              lsb_done,
  output logic [31:0]       lsb_res,
  input  logic              if_enable,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  mc_state_e         state;
  mc_state_e         state_n;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        size_q;
  logic [6:0]        op_q;
  logic [31:0]       wdata_q;
  logic              is_lsb_q;
  logic [31:0]       rbuf;

  logic              acc_lsb;
  logic              acc_if;
  logic              acc_st;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        k_rd;
  logic [1:0]        cap_idx;
  logic [1:0]        last_idx;
  logic              rd_fin;
  logic [2:0]        nidx;
  logic              wr_fin;
  logic [31:0]       asm_word;
  logic [31:0]       ext_res;
  logic              bp_acc;
  logic              bp_wr;

  assign acc_lsb = (state == MC_IDLE)
                 && !wrong_commit
                 && lsb_enable;
  assign acc_if  = (state == MC_IDLE)
                 && !wrong_commit
                 && !lsb_enable
                 && if_enable;
  assign acc_st  = acc_lsb && !lsb_is_load;
  assign acc_addr = acc_lsb ? lsb_addr : if_addr;

  // Read pipeline: address k goes out after edge k,
  // its byte arrives two edges later.
  assign k_rd     = cnt + 3'd1;
  assign cap_idx  = 2'(k_rd - 3'd2);
  assign last_idx = 2'(size_q - 3'd1);
  assign rd_fin   = (k_rd == size_q + 3'd1);

  // A byte is committed on each edge that saw mem_wr high.
  assign nidx   = cnt + {2'b00, mem_wr};
  assign wr_fin = (nidx == size_q);

`ifdef MC_IO_BACKPRESSURE_EN
  assign bp_acc = (lsb_addr[17:16] == IO_BASE_HI)
                && io_buffer_full;
  assign bp_wr  = (base_q[17:16] == IO_BASE_HI)
                && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign bp_acc    = 1'b0;
  assign bp_wr     = 1'b0;
`endif

  always_comb begin
    asm_word = rbuf;
    asm_word[{last_idx, 3'b000} +: 8] = mem_din;
  end

  mem_load_ext u_ext (
    .op   (op_q),
    .word (asm_word),
    .res  (ext_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MC_IDLE;
    end else if (rdy) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MC_IDLE: begin
        if (acc_st) begin
          state_n = MC_WRITE;
        end else if (acc_lsb || acc_if) begin
          state_n = MC_READ;
        end
      end
      MC_READ: begin
        if (wrong_commit) begin
          state_n = MC_IDLE;
        end else if (rd_fin) begin
          state_n = MC_DONE;
        end
      end
      MC_WRITE: begin
        if (wr_fin) begin
          state_n = MC_DONE;
        end
      end
      MC_DONE: begin
        state_n = MC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      base_q   <= '0;
      size_q   <= '0;
      op_q     <= '0;
      wdata_q  <= '0;
      is_lsb_q <= 1'b0;
      rbuf     <= '0;
      lsb_done <= 1'b0;
      lsb_res  <= '0;
      if_done  <= 1'b0;
      if_inst  <= '0;
      mem_dout <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
    end else if (rdy) begin
      unique case (state)
        MC_IDLE: begin
          if (acc_lsb || acc_if) begin
            base_q   <= acc_addr;
            size_q   <= acc_lsb ? op_size(lsb_op)
                                : SZ_W;
            op_q     <= acc_lsb ? lsb_op : OP_LW;
            wdata_q  <= lsb_data;
            is_lsb_q <= acc_lsb;
            cnt      <= '0;
            mem_a    <= acc_addr;
            if (acc_st) begin
              mem_dout <= lsb_data[7:0];
              mem_wr   <= !bp_acc;
            end else begin
              mem_wr   <= 1'b0;
            end
          end
        end
        MC_READ: begin
          if (wrong_commit) begin
            cnt    <= '0;
            mem_a  <= '0;
            mem_wr <= 1'b0;
          end else begin
            cnt <= k_rd;
            if (k_rd < size_q) begin
              mem_a <= base_q + ADDR_W'(k_rd);
            end
            if (k_rd >= 3'd2) begin
              rbuf[{cap_idx, 3'b000} +: 8] <= mem_din;
            end
            if (rd_fin) begin
              mem_a <= '0;
              if (is_lsb_q) begin
                lsb_done <= 1'b1;
                lsb_res  <= ext_res;
              end else begin
                if_done  <= 1'b1;
                if_inst  <= asm_word;
              end
            end
          end
        end
        MC_WRITE: begin
          cnt <= nidx;
          if (wr_fin) begin
            mem_wr   <= 1'b0;
            mem_a    <= '0;
            lsb_done <= 1'b1;
            lsb_res  <= '0;
          end else begin
            mem_a    <= base_q + ADDR_W'(nidx);
            mem_dout <= wdata_q[{nidx[1:0], 3'b000} +: 8];
            mem_wr   <= !bp_wr;
          end
        end
        MC_DONE: begin
          lsb_done <= 1'b0;
          if_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a
// byte-wide synchronous RAM model gated by rdy.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        wrong_commit = 1'b0;
  logic        lsb_enable = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_data = '0;
  logic        lsb_is_load = 1'b0;
  logic [6:0]  lsb_op = '0;
  logic        lsb_done;
  logic [31:0] lsb_res;
  logic        if_enable = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_inst;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ram [0:262143];
  logic [39:0] wq[$];
  logic        pl_en = 1'b0;
  logic [17:0] pl_a = '0;
  logic [7:0]  pl_d = '0;

  mem_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .wrong_commit   (wrong_commit),
    .lsb_enable     (lsb_enable),
    .lsb_addr       (lsb_addr),
    .lsb_data       (lsb_data),
    .lsb_is_load    (lsb_is_load),
    .lsb_op         (lsb_op),
    .lsb_done       (lsb_done),
    .lsb_res        (lsb_res),
    .if_enable      (if_enable),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_inst        (if_inst),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (rdy) begin
      if (mem_wr) begin
        ram[mem_a[17:0]] <= mem_dout;
        wq.push_back({mem_a, mem_dout});
      end
      mem_din <= ram[mem_a[17:0]];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic poke(input logic [17:0] a,
                      input logic [7:0] d);
    pl_a = a;
    pl_d = d;
    pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One request; lat counts cycles from the accept edge.
  task automatic run(input bit fetch,
                     input logic [6:0] op,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input int wc_t,
                     input int st_t,
                     input int st_n,
                     input logic [31:0] st_a,
                     input int io_n,
                     output logic [31:0] res,
                     output int lat,
                     output logic [31:0] tr);
    lat = -1;
    res = '0;
    tr = '0;
    if (fetch) begin
      if_addr = a;
      if_enable = 1'b1;
    end else begin
      lsb_addr = a;
      lsb_data = d;
      lsb_op = op;
      lsb_is_load = op inside
        {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
      lsb_enable = 1'b1;
    end
    wrong_commit = (wc_t == 0);
    io_buffer_full = (io_n > 0);
    rdy = 1'b1;
    for (int t = 1; t <= 30 && lat < 0; t++) begin
      @(posedge clk); #1;
      tr[t] = mem_wr;
      if (st_n > 0 && t == st_t + st_n)
        chk("stall mem_a", mem_a, st_a);
      if (fetch && wc_t > 0 && t == wc_t + 1) begin
        chk("flush mem_a", mem_a, 0);
        if_enable = 1'b0;
      end
      wrong_commit = (t == wc_t);
      io_buffer_full = (t < io_n);
      rdy = !(st_n > 0 && t >= st_t
              && t < st_t + st_n);
      if (fetch ? if_done : lsb_done) begin
        lat = t - 1;
        res = fetch ? if_inst : lsb_res;
      end
    end
    lsb_enable = 1'b0;
    if_enable = 1'b0;
    wrong_commit = 1'b0;
    io_buffer_full = 1'b0;
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("pulse width", {lsb_done, if_done}, 0);
  endtask

  logic [31:0] res;
  logic [31:0] tr;
  logic [31:0] v;
  logic [31:0] lres;
  logic [31:0] fres;
  int lat;
  int lt;
  int ft;
  int nl;
  int nf;
  int both;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst lsb_done", lsb_done, 0);
    chk("rst if_done", if_done, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst mem_a", mem_a, 0);
    chk("rst mem_dout", mem_dout, 0);
    chk("rst lsb_res", lsb_res, 0);
    chk("rst if_inst", if_inst, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    poke(18'h00200, 8'h80);
    poke(18'h3FFFF, 8'h11);
    poke(18'h00000, 8'h22);
    poke(18'h00400, 8'h13);
    poke(18'h00401, 8'h05);
    poke(18'h00402, 8'h50);
    poke(18'h00403, 8'h00);
    wq.delete();

    run(0, OP_SW, 32'h100, 32'hDEADBEEF,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("sw lat", lat, 4);
    chk("sw res", res, 0);
    chk("sw wr trace", tr[5:1], 5'b01111);
    chk("sw nwrites", wq.size(), 4);
    v = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      chk("sw byte",
          (i < wq.size()) ? wq[i] : 40'h0,
          {32'h100 + 32'(i), v[8*i +: 8]});
    end

    run(0, OP_LW, 32'h100, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("lw res", res, 32'hDEADBEEF);
    chk("lw lat", lat, 5);

    run(0, OP_LB, 32'h200, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("lb res", res, 32'hFFFFFF80);
    chk("lb lat", lat, 2);
    run(0, OP_LBU, 32'h200, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("lbu res", res, 32'h00000080);

    poke(18'h00200, 8'h34);
    poke(18'h00201, 8'h92);
    run(0, OP_LH, 32'h200, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("lh res", res, 32'hFFFF9234);
    chk("lh lat", lat, 3);
    run(0, OP_LHU, 32'h200, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("lhu res", res, 32'h00009234);
    run(0, OP_LHU, 32'hFFFFFFFF, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("lhu wrap", res, 32'h00002211);

    // LSB and fetch request together
    lsb_addr = 32'h100;
    lsb_op = OP_LW;
    lsb_is_load = 1'b1;
    lsb_enable = 1'b1;
    if_addr = 32'h400;
    if_enable = 1'b1;
    lt = -1; ft = -1; nl = 0; nf = 0; both = 0;
    lres = '0; fres = '0;
    for (int t = 1; t <= 25; t++) begin
      @(posedge clk); #1;
      if (lsb_done && if_done) both++;
      if (lsb_done) begin
        nl++; lt = t; lres = lsb_res;
      end
      if (if_done) begin
        nf++; ft = t; fres = if_inst;
      end
      if (lt > 0 && t == lt + 1) lsb_enable = 1'b0;
      if (ft > 0 && t == ft + 1) if_enable = 1'b0;
    end
    lsb_enable = 1'b0;
    if_enable = 1'b0;
    chk("arb lsb time", lt, 6);
    chk("arb if time", ft, 13);
    chk("arb lsb count", nl, 1);
    chk("arb if count", nf, 1);
    chk("arb overlap", both, 0);
    chk("arb lsb res", lres, 32'hDEADBEEF);
    chk("arb if inst", fres, 32'h00500513);

    run(1, OP_LW, 32'h400, 0,
        2, 0, 0, 0, 0, res, lat, tr);
    chk("fetch flush no done", lat, -1);
    run(0, OP_LB, 32'h200, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("post flush lat", lat, 2);
    chk("post flush res", res, 32'h00000034);
    run(0, OP_LB, 32'h200, 0,
        0, 0, 0, 0, 0, res, lat, tr);
    chk("idle flush lat", lat, 3);

    wq.delete();
    run(0, OP_SW, 32'h500, 32'h11223344,
        2, 0, 0, 0, 0, res, lat, tr);
    chk("sw flush lat", lat, 4);
    chk("sw flush nwrites", wq.size(), 4);
    run(0, OP_LW, 32'h500, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("sw flush readback", res, 32'h11223344);

    run(0, OP_LW, 32'h100, 0,
        -1, 2, 3, 32'h101, 0, res, lat, tr);
    chk("stall res", res, 32'hDEADBEEF);
    chk("stall lat", lat, 8);

    wq.delete();
    run(0, OP_SB, 32'h30000, 32'h41,
        -1, 0, 0, 0, 2, res, lat, tr);
    chk("io nwrites", wq.size(), 1);
    chk("io write",
        (wq.size() > 0) ? wq[0] : 40'h0,
        {32'h30000, 8'h41});
`ifdef MC_IO_BACKPRESSURE_EN
    chk("io lat", lat, 3);
    chk("io wr trace", tr[4:1], 4'b0100);
`else
    chk("io lat", lat, 1);
    chk("io wr trace", tr[4:1], 4'b0001);
`endif
    run(0, OP_SB, 32'h104, 32'h5A,
        -1, 0, 0, 0, 2, res, lat, tr);
    chk("non-io sb lat", lat, 1);

    // async reset in the middle of a load
    lsb_addr = 32'h100;
    lsb_op = OP_LW;
    lsb_is_load = 1'b1;
    lsb_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre rst mem_a", mem_a, 32'h102);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst mem_a", mem_a, 0);
    lsb_enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(0, OP_LW, 32'h100, 0,
        -1, 0, 0, 0, 0, res, lat, tr);
    chk("post rst lat", lat, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
